// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the wide_add_seq sequential wide adder.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_slice.sv
// N-bit combinational ripple-carry full adder; the only arithmetic in wide_add_seq.
module add_slice #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/wide_add_seq.sv
// Adds two N*WORDS-bit operands one N-bit word per clock, LS word first.
// Optional signed-overflow output ovf is enabled by defining WIDE_ADD_SEQ_OVF_EN.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] sum,
  output logic               cout
`ifdef WIDE_ADD_SEQ_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int W  = N * WORDS;
  localparam int IW = (clog2(WORDS) < 1) ? 1 : clog2(WORDS);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  state_t        state_reg;
  logic [W-1:0]  a_sh_reg;
  logic [W-1:0]  b_sh_reg;
  logic [W-1:0]  sum_reg;
  logic          carry_reg;
  logic [IW-1:0] idx_reg;
  logic          cout_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [N-1:0]  slice_sum;
  logic          slice_cout;
  logic [W-1:0]  sum_next;

  add_slice #(.N(N)) u_slice (
    .a    (a_sh_reg[N-1:0]),
    .b    (b_sh_reg[N-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // The result fills from the top so that after WORDS passes the LS word sits at bit 0.
  if (WORDS == 1) begin : g_one_word
    assign sum_next = slice_sum;
  end else begin : g_multi_word
    assign sum_next = {slice_sum, sum_reg[W-1:N]};
  end

`ifdef WIDE_ADD_SEQ_OVF_EN
  logic ovf_reg;
  logic msb_carry_in;

  // Carry into the slice MSB is recovered from its sum bit and operand bits.
  assign msb_carry_in = a_sh_reg[N-1] ^ b_sh_reg[N-1] ^ slice_sum[N-1];
  assign ovf          = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef WIDE_ADD_SEQ_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            sum_reg   <= '0;
            busy_reg  <= 1'b1;
`ifdef WIDE_ADD_SEQ_OVF_EN
            ovf_reg   <= 1'b0;
`endif
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          a_sh_reg  <= a_sh_reg >> N;
          b_sh_reg  <= b_sh_reg >> N;
          carry_reg <= slice_cout;
          idx_reg   <= idx_reg + IW'(1);
          if (idx_reg == IDX_LAST) begin
            cout_reg  <= slice_cout;
`ifdef WIDE_ADD_SEQ_OVF_EN
            ovf_reg   <= msb_carry_in ^ slice_cout;
`endif
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq at N=4, WORDS=4 (W=16).
module tb_wide_add_seq;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;
  localparam int LAT   = WORDS + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef WIDE_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   done_cnt;
  int   exp_done;

  wide_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef WIDE_ADD_SEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  // Called at a negedge while the DUT is idle; the next rising edge accepts it.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    sb.push_back(model(x, y, ci));
    exp_done++;
    $display("launch a=%04h b=%04h cin=%0d", x, y, ci);
  endtask

  task automatic wait_done(input string tag);
    int cycles;
    int busy_cycles;
    cycles      = 0;
    busy_cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) break;
      if (cycles > 4 * LAT) begin
        check({tag, "_timeout"}, 64'(cycles), 64'(LAT));
        return;
      end
    end
    check({tag, "_latency"}, 64'(cycles), 64'(LAT));
    check({tag, "_busy_len"}, 64'(busy_cycles), 64'(LAT));
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
    check({tag, "_done_after"}, 64'(done), 64'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result sum=%04h cout=%0d (exp %04h/%0d)", sum, cout, e.sum, e.cout);
        check("sum", 64'(sum), 64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
`ifdef WIDE_ADD_SEQ_OVF_EN
        check("ovf", 64'(ovf), 64'(e.ovf));
`endif
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    done_cnt = 0;
    exp_done = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
`ifdef WIDE_ADD_SEQ_OVF_EN
    check("rst_ovf", 64'(ovf), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    launch(16'd1, 16'd2, 1'b0);
    wait_done("small");
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done("ripple");
    launch(16'd11, 16'd12, 1'b1);
    wait_done("cin");

    // Result must hold while idle, up to the next accepted start.
    repeat (3) begin
      @(negedge clk);
      check("hold_sum", 64'(sum), 64'd24);
    end
    launch(16'h8000, 16'h8000, 1'b0);
    wait_done("top_carry");

    // Start held high with changing operands: only IDLE-time requests count.
    launch(16'h1357, 16'h2468, 1'b0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) break;
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
    end
    launch(16'hABCD, 16'h1111, 1'b1);
    wait_done("hammer");

    // Reset during the second RUN cycle discards the add in flight.
    launch(16'h1234, 16'h0F0F, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_done--;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    launch(16'h4321, 16'h1234, 1'b0);
    wait_done("after_rst");

`ifdef WIDE_ADD_SEQ_OVF_EN
    launch(16'h7FFF, 16'h0001, 1'b0);
    wait_done("ovf_pos");
    launch(16'hFFFF, 16'h0001, 1'b0);
    wait_done("ovf_neg");
`endif

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      launch(a, b, 1'($urandom));
      wait_done("random");
    end

    repeat (3) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
